// File: rtl/inv_sub_byte_seq.sv
// inv_sub_byte_seq: multi-cycle AES InvSubBytes engine.
// Substitutes the 16 bytes of a 128-bit state LANES bytes per clock through
// LANES inverse S-box instances, with valid/ready handshakes on both sides.
// Optional feature macro: SUBBYTE_FWD_SEL_EN adds a per-block 'decrypt' input
// and forward S-box lanes so one engine serves encrypt and decrypt paths.

// Combinational 256-entry FIPS-197 inverse S-box.
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign o_byte = INV_TABLE[i_byte];
endmodule

`ifdef SUBBYTE_FWD_SEL_EN
// Combinational 256-entry FIPS-197 forward S-box.
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_byte = FWD_TABLE[i_byte];
endmodule
`endif

module inv_sub_byte_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
`ifdef SUBBYTE_FWD_SEL_EN
  input  logic         decrypt,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_byte_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [0:15][7:0]      r_work;      // element 0 is the MSB byte, byte 0 of the state
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [3:0]            w_base;
  logic [7:0]            w_lane_out [LANES];
`ifdef SUBBYTE_FWD_SEL_EN
  logic                  r_decrypt;
`endif

  // First byte index of the group handled in the current RUN cycle.
  assign w_base = 4'(int'(r_cnt) * LANES);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] w_lane_in;
    logic [7:0] w_inv;
    assign w_lane_in = r_work[w_base + 4'(k)];
    inv_sbox u_inv (.i_byte(w_lane_in), .o_byte(w_inv));
`ifdef SUBBYTE_FWD_SEL_EN
    logic [7:0] w_fwd;
    sbox u_fwd (.i_byte(w_lane_in), .o_byte(w_fwd));
    assign w_lane_out[k] = r_decrypt ? w_inv : w_fwd;
`else
    assign w_lane_out[k] = w_inv;
`endif
  end

  // Control FSM and working register; all outputs come straight from flops.
  // NOTE: every state update here uses <= so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SUBBYTE_FWD_SEL_EN
      r_decrypt   <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work     <= data_in;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef SUBBYTE_FWD_SEL_EN
            r_decrypt  <= decrypt;
`endif
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < LANES; k++) begin
            r_work[w_base + 4'(k)] <= w_lane_out[k];
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(NCYC - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign data_out  = r_work;
endmodule

// File: tb/tb_inv_sub_byte_seq.sv
// Testbench for inv_sub_byte_seq: five instances (LANES = 1, 2, 4, 8, 16)
// share one stimulus stream; each has a scoreboard monitor fed by a GF(2^8)
// reference model of the AES S-box and its inverse.
module tb_inv_sub_byte_seq;
  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [127:0] data_in;
  logic         out_ready;
  logic         decrypt;
  logic [4:0]   w_in_ready;
  logic [4:0]   w_out_valid;
  logic [4:0]   w_busy;
  logic [127:0] w_data_out [5];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic end_chk = 1'b0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] d, input logic dec);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = dec ? inv_tab[d[127-8*i -: 8]] : fwd_tab[d[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- DUT instances + per-instance scoreboards ----------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam int L  = 1 << gi;
    localparam int NC = 16 / L;

    inv_sub_byte_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (w_in_ready[gi]),
      .data_in   (data_in),
`ifdef SUBBYTE_FWD_SEL_EN
      .decrypt   (decrypt),
`endif
      .out_valid (w_out_valid[gi]),
      .out_ready (out_ready),
      .data_out  (w_data_out[gi]),
      .busy      (w_busy[gi])
    );

    logic [127:0] exp_q [$];
    int           acc_cyc  = 0;
    logic         prev_ov  = 1'b0;
    logic         prev_or  = 1'b0;
    logic         prev_hs  = 1'b0;
    logic [127:0] prev_do  = '0;
    logic         rst_pend = 1'b0;
    logic         end_done = 1'b0;

    always @(negedge clk) begin
      if (reset) begin
        exp_q.delete();
        rst_pend = 1'b1;
        prev_ov  = 1'b0;
        prev_hs  = 1'b0;
      end else begin
        if (rst_pend) begin
          check($sformatf("L%0d reset out_valid", L), w_out_valid[gi], 0);
          check($sformatf("L%0d reset data_out", L), w_data_out[gi], 0);
          check($sformatf("L%0d reset in_ready", L), w_in_ready[gi], 1);
          check($sformatf("L%0d reset busy", L), w_busy[gi], 0);
          rst_pend = 1'b0;
        end
        if (prev_ov && !prev_or) begin
          check($sformatf("L%0d hold out_valid", L), w_out_valid[gi], 1);
          check($sformatf("L%0d hold data_out", L), w_data_out[gi], prev_do);
        end
        if (prev_hs) begin
          check($sformatf("L%0d release in_ready", L), w_in_ready[gi], 1);
          check($sformatf("L%0d release out_valid", L), w_out_valid[gi], 0);
        end
        check($sformatf("L%0d busy vs in_ready", L), w_busy[gi], !w_in_ready[gi]);
        if (exp_q.size() != 0)
          check($sformatf("L%0d in_ready while outstanding", L), w_in_ready[gi], 0);
        if (w_out_valid[gi] && !prev_ov)
          check($sformatf("L%0d latency", L), 128'(cyc - acc_cyc), 128'(NC + 1));
        if (w_out_valid[gi] && out_ready) begin
          check($sformatf("L%0d output has a pending block", L), 128'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0)
            check($sformatf("L%0d data", L), w_data_out[gi], exp_q.pop_front());
        end
        if (in_valid && w_in_ready[gi]) begin
          exp_q.push_back(ref_block(data_in, decrypt));
          acc_cyc = cyc;
        end
        prev_hs = w_out_valid[gi] && out_ready;
        prev_ov = w_out_valid[gi];
        prev_or = out_ready;
        prev_do = w_data_out[gi];
      end
      if (end_chk && !end_done) begin
        check($sformatf("L%0d queue drained", L), 128'(exp_q.size()), 0);
        end_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (w_in_ready != 5'h1f && n < 100) begin
      step();
      n++;
    end
    check("wait all in_ready", w_in_ready, 5'h1f);
  endtask

  // One block into every instance at once; each output compared to a known value.
  task automatic send_directed(input string name, input logic [127:0] v,
                               input logic [127:0] exp, input logic dec);
    logic [4:0] seen = '0;
    wait_all_ready();
    in_valid  = 1'b1;
    data_in   = v;
    decrypt   = dec;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 40 && seen != 5'h1f; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (w_out_valid[i] && !seen[i]) begin
          check($sformatf("%s lane%0d", name, 1 << i), w_data_out[i], exp);
          seen[i] = 1'b1;
        end
      end
      data_in = rand128();
      decrypt = 1'($urandom_range(0, 1));
      step();
    end
    check($sformatf("%s all finished", name), seen, 5'h1f);
    decrypt = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    decrypt   = 1'b1;
    for (int x = 0; x < 256; x++) begin
      fwd_tab[x] = sbox_math(8'(x));
      inv_tab[fwd_tab[x]] = 8'(x);
    end
    repeat (3) step();
    reset = 1'b0;
    step();

    send_directed("fips vector", 128'h637c777bf26b6fc53001672bfed7ab76,
                  128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    send_directed("all 63", {16{8'h63}}, 128'h0, 1'b1);
    send_directed("all 16", {16{8'h16}}, {16{8'hff}}, 1'b1);

    // Stall in DONE with in_valid held high: nothing new may be accepted.
    wait_all_ready();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = rand128();
    step();
    for (int n = 0; n < 28; n++) begin
      data_in = rand128();
      step();
    end
    check("stall out_valid", w_out_valid, 5'h1f);
    check("stall in_ready", w_in_ready, 5'h00);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    step();
    check("after release out_valid", w_out_valid, 5'h00);
    check("after release in_ready", w_in_ready, 5'h1f);
    out_ready = 1'b1;

    // Reset during the second RUN cycle, then a fresh block.
    wait_all_ready();
    in_valid = 1'b1;
    data_in  = rand128();
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_directed("after abort", {16{8'h63}}, 128'h0, 1'b1);

`ifdef SUBBYTE_FWD_SEL_EN
    send_directed("forward", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, 1'b0);
    send_directed("inverse", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h52096ad53036a538bf40a39e81f3d7fb, 1'b1);
`endif

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = rand128();
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef SUBBYTE_FWD_SEL_EN
      decrypt   = 1'($urandom_range(0, 1));
`endif
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_all_ready();
    step();

    end_chk = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
